// File: rtl/lsu_unit.sv
// Load/store stage: turns an ALU address and rs2 into one word-aligned memory
// request, formats load data, and reports misalignment/illegal-width/timeout faults.
module lsu_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata_out,
  output logic [1:0]  err_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  state_t      state_r;
  state_t      state_s;
  logic        load_r;
  logic [2:0]  funct3_r;
  logic [1:0]  addr_lo_r;
  logic [7:0]  cnt_r;
  logic        accept_s;
  logic        illegal_s;
  logic        misaligned_s;
  logic        timeout_s;
  logic [1:0]  err_s;

  // Shift the returned word down to the addressed lane, then extend per width code.
  function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  lo);
    logic [31:0] sh;
    sh = word >> {lo, 3'b000};
    case (f3)
      3'b000:  fmt_load = {{24{sh[7]}}, sh[7:0]};
      3'b001:  fmt_load = {{16{sh[15]}}, sh[15:0]};
      3'b010:  fmt_load = sh;
      3'b100:  fmt_load = {24'd0, sh[7:0]};
      3'b101:  fmt_load = {16'd0, sh[15:0]};
      default: fmt_load = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] fmt_store_data(input logic [31:0] wd,
                                                 input logic [2:0]  f3);
    case (f3[1:0])
      2'b00:   fmt_store_data = {4{wd[7:0]}};
      2'b01:   fmt_store_data = {2{wd[15:0]}};
      default: fmt_store_data = wd;
    endcase
  endfunction

  function automatic logic [3:0] fmt_store_strb(input logic [2:0] f3,
                                                input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   fmt_store_strb = 4'b0001 << lo;
      2'b01:   fmt_store_strb = lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   fmt_store_strb = 4'b1111;
      default: fmt_store_strb = 4'b0000;
    endcase
  endfunction

  assign busy = (state_r != S_IDLE);

  // Classify the incoming request: width legality depends on load vs store.
  always_comb begin
    illegal_s    = 1'b0;
    misaligned_s = 1'b0;
    if (is_load) begin
      illegal_s = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    end else begin
      illegal_s = !((funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010));
    end
    case (funct3)
      3'b001, 3'b101: misaligned_s = addr[0];
      3'b010:         misaligned_s = (addr[1:0] != 2'b00);
      default:        misaligned_s = 1'b0;
    endcase
  end

  assign timeout_s = ((cnt_r + 8'd1) == TIMEOUT_LIMIT);

  // Next-state logic; ack is tested before timeout so it wins on a tie.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    err_s    = ERR_OK;
    case (state_r)
      S_IDLE: begin
        if (valid_in && (is_load || is_store)) begin
          accept_s = 1'b1;
          if (illegal_s) begin
            state_s = S_RESP;
            err_s   = ERR_ILLEGAL;
          end else if (misaligned_s) begin
            state_s = S_RESP;
            err_s   = ERR_MISALIGN;
          end else begin
            state_s = S_WAIT;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          state_s = S_RESP;
          err_s   = ERR_OK;
        end else if (timeout_s) begin
          state_s = S_RESP;
          err_s   = ERR_TIMEOUT;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_RESP:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State, memory port and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      load_r    <= 1'b0;
      funct3_r  <= 3'b000;
      addr_lo_r <= 2'b00;
      cnt_r     <= 8'd0;
      done      <= 1'b0;
      rdata_out <= 32'd0;
      err_code  <= ERR_OK;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wstrb <= 4'b0000;
    end else begin
      state_r <= state_s;
      done    <= (state_s == S_RESP);
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            load_r    <= is_load;
            funct3_r  <= funct3;
            addr_lo_r <= addr[1:0];
            cnt_r     <= 8'd0;
            if (state_s == S_WAIT) begin
              mem_req   <= 1'b1;
              mem_we    <= !is_load;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= is_load ? 32'd0 : fmt_store_data(wdata_in, funct3);
              mem_wstrb <= is_load ? 4'b0000 : fmt_store_strb(funct3, addr[1:0]);
            end else begin
              err_code  <= err_s;
              rdata_out <= 32'd0;
            end
          end
        end
        S_WAIT: begin
          if (state_s == S_RESP) begin
            mem_req   <= 1'b0;
            err_code  <= err_s;
            rdata_out <= (mem_ack && load_r) ? fmt_load(mem_rdata, funct3_r, addr_lo_r)
                                             : 32'd0;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
          cnt_r <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit: directed vector table, hand-written
// multi-cycle sequences, and randomized accesses against a behavioural model.
module tb_lsu_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata_in;
  logic        busy, done;
  logic [31:0] rdata_out;
  logic [1:0]  err_code;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  lsu_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata_in(wdata_in), .busy(busy), .done(done),
    .rdata_out(rdata_out), .err_code(err_code), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  err;
    logic [31:0] rdata;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  wstrb;
    logic        we;
    int          lat;
    int          reqc;
  } res_t;

  typedef struct {
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] a, wd, rd;
    int          d;
    logic [1:0]  err;
    logic [31:0] rdata, wdata;
    logic [3:0]  wstrb;
    int          lat, reqc;
  } vec_t;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] prev_exp_rdata = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: width, alignment and lane selection computed arithmetically.
  function automatic res_t model(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rd, input int d);
    res_t   e;
    int     size;
    longint v;
    bit     illegal;
    e       = '{default: 0};
    size    = 1 << (f3 % 4);
    illegal = ld ? (f3 == 3 || f3 == 6 || f3 == 7) : (f3 > 2);
    e.maddr = a - (a % 4);
    e.we    = !ld;
    if (illegal) begin
      e.err = 2'd3; e.lat = 1;
    end else if ((a % size) != 0) begin
      e.err = 2'd1; e.lat = 1;
    end else begin
      if (d < TO) begin
        e.lat = d + 2; e.reqc = d + 1;
        if (ld) begin
          v = longint'(rd >> (8 * (a % 4))) % (longint'(1) << (8 * size));
          if (f3 < 4 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
            v = v - (longint'(1) << (8 * size));
          e.rdata = 32'(v);
        end
      end else begin
        e.err = 2'd2; e.lat = TO + 1; e.reqc = TO;
      end
      if (!ld) begin
        e.mwdata = (size == 1) ? (wd % 256) * 32'h0101_0101 :
                   (size == 2) ? (wd % 65536) * 32'h0001_0001 : wd;
        e.wstrb  = 4'(((1 << size) - 1) << (a % 4));
      end
    end
    return e;
  endfunction

  // Issue one access in a cycle where busy is low; ack arrives d WAIT cycles in.
  task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input int d, output res_t r);
    int   k, waitn;
    bit   got, stable_bad;
    r = '{default: 0};
    valid_in = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; wdata_in = wd;
    tick;
    valid_in = 1'b0; is_load = 1'b0; is_store = 1'b0;
    funct3 = 3'($urandom); addr = $urandom; wdata_in = $urandom;
    k = 1; waitn = 0; got = 0; stable_bad = 0;
    while (k <= 40 && !got) begin
      mem_ack = 1'b0;
      if (mem_req) begin
        if (r.reqc == 0) begin
          r.maddr = mem_addr; r.mwdata = mem_wdata; r.wstrb = mem_wstrb; r.we = mem_we;
          check("hold_rdata", rdata_out, prev_exp_rdata);
        end else if (mem_addr !== r.maddr || mem_wdata !== r.mwdata ||
                     mem_wstrb !== r.wstrb || mem_we !== r.we) begin
          stable_bad = 1;
        end
        if (waitn == d) begin
          mem_ack = 1'b1; mem_rdata = rd;
        end else begin
          mem_rdata = $urandom;
        end
        waitn++;
        r.reqc++;
      end
      if (done) begin
        got = 1; r.lat = k; r.err = err_code; r.rdata = rdata_out;
      end else begin
        tick;
        k++;
      end
    end
    mem_ack = 1'b0;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL done_bound: no done within 40 cycles");
    end
    check("wait_stable", 32'(stable_bad), 32'd0);
    tick;
    check("busy_after_done", 32'(busy), 32'd0);
    check("done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic compare_res(input string tag, input res_t e, input res_t a, input logic ld);
    check({tag, "_err"}, 32'(a.err), 32'(e.err));
    check({tag, "_rdata"}, a.rdata, e.rdata);
    check({tag, "_latency"}, 32'(a.lat), 32'(e.lat));
    check({tag, "_req_cycles"}, 32'(a.reqc), 32'(e.reqc));
    if (e.reqc > 0) begin
      check({tag, "_mem_addr"}, a.maddr, e.maddr);
      check({tag, "_mem_we"}, 32'(a.we), 32'(e.we));
      check({tag, "_wstrb"}, 32'(a.wstrb), 32'(e.wstrb));
      if (!ld) check({tag, "_wdata"}, a.mwdata, e.mwdata);
    end
    prev_exp_rdata = e.rdata;
  endtask

  vec_t vecs[13];
  res_t exp_r, act_r;
  bit   stray_done;

  initial begin
    vecs[0]  = '{1, 0, 3'b000, 32'h1003, 32'h0,         32'h80FF_1234, 0,   2'd0, 32'hFFFF_FF80, 32'h0,         4'h0, 2,  1};
    vecs[1]  = '{0, 1, 3'b001, 32'h2002, 32'h1234_ABCD, 32'h0,         1,   2'd0, 32'h0,         32'hABCD_ABCD, 4'hC, 3,  2};
    vecs[2]  = '{1, 0, 3'b010, 32'h3001, 32'h0,         32'h0,         0,   2'd1, 32'h0,         32'h0,         4'h0, 1,  0};
    vecs[3]  = '{1, 0, 3'b101, 32'h0,    32'h0,         32'h0000_8001, 0,   2'd0, 32'h0000_8001, 32'h0,         4'h0, 2,  1};
    vecs[4]  = '{1, 0, 3'b010, 32'h4000, 32'h0,         32'h0,         255, 2'd2, 32'h0,         32'h0,         4'h0, 17, 16};
    vecs[5]  = '{0, 1, 3'b100, 32'h4000, 32'hDEAD_BEEF, 32'h0,         0,   2'd3, 32'h0,         32'h0,         4'h0, 1,  0};
    vecs[6]  = '{1, 0, 3'b000, 32'h0,    32'h0,         32'h0000_007F, 15,  2'd0, 32'h0000_007F, 32'h0,         4'h0, 17, 16};
    vecs[7]  = '{0, 1, 3'b000, 32'h5,    32'hAABB_CC5A, 32'h0,         2,   2'd0, 32'h0,         32'h5A5A_5A5A, 4'h2, 4,  3};
    vecs[8]  = '{1, 0, 3'b001, 32'h6,    32'h0,         32'h8001_0000, 0,   2'd0, 32'hFFFF_8001, 32'h0,         4'h0, 2,  1};
    vecs[9]  = '{1, 0, 3'b011, 32'h8,    32'h0,         32'h0,         0,   2'd3, 32'h0,         32'h0,         4'h0, 1,  0};
    vecs[10] = '{1, 0, 3'b001, 32'h1,    32'h0,         32'h0,         0,   2'd1, 32'h0,         32'h0,         4'h0, 1,  0};
    vecs[11] = '{1, 0, 3'b100, 32'h2,    32'h0,         32'h00F0_0000, 0,   2'd0, 32'h0000_00F0, 32'h0,         4'h0, 2,  1};
    vecs[12] = '{1, 1, 3'b010, 32'h10,   32'h5555_5555, 32'h1234_5678, 0,   2'd0, 32'h1234_5678, 32'h0,         4'h0, 2,  1};

    rst = 1'b1; valid_in = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'd0; wdata_in = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    tick; tick;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rdata", rdata_out, 32'd0);
    check("rst_err", 32'(err_code), 32'd0);
    rst = 1'b0;

    // Directed vectors; consecutive calls also exercise back-to-back acceptance.
    for (int i = 0; i < 13; i++) begin
      exp_r = '{default: 0};
      exp_r.err = vecs[i].err; exp_r.rdata = vecs[i].rdata; exp_r.mwdata = vecs[i].wdata;
      exp_r.wstrb = vecs[i].wstrb; exp_r.lat = vecs[i].lat; exp_r.reqc = vecs[i].reqc;
      exp_r.maddr = {vecs[i].a[31:2], 2'b00}; exp_r.we = !vecs[i].ld;
      run_access(vecs[i].ld, vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].rd,
                 vecs[i].d, act_r);
      compare_res($sformatf("vec%0d", i), exp_r, act_r, vecs[i].ld);
    end

    // No access type and a stray ack while idle: nothing happens.
    valid_in = 1'b1; is_load = 1'b0; is_store = 1'b0;
    tick;
    valid_in = 1'b0;
    check("noop_busy", 32'(busy), 32'd0);
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    check("stray_ack_busy", 32'(busy), 32'd0);
    check("stray_ack_done", 32'(done), 32'd0);

    // valid_in while busy is dropped, not queued.
    valid_in = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h100;
    tick;
    check("busy_in_wait", 32'(busy), 32'd1);
    is_load = 1'b0; is_store = 1'b1; funct3 = 3'b000; addr = 32'h203;
    tick;
    valid_in = 1'b0; is_store = 1'b0;
    check("ignored_we", 32'(mem_we), 32'd0);
    check("ignored_addr", mem_addr, 32'h100);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick;
    mem_ack = 1'b0;
    check("busy_seq_done", 32'(done), 32'd1);
    check("busy_seq_rdata", rdata_out, 32'hCAFE_F00D);
    tick;
    tick;
    check("not_queued_req", 32'(mem_req), 32'd0);
    check("not_queued_busy", 32'(busy), 32'd0);
    prev_exp_rdata = 32'hCAFE_F00D;

    // Reset in the third WAIT cycle aborts silently.
    valid_in = 1'b1; is_load = 1'b1; funct3 = 3'b010; addr = 32'h200;
    tick;
    valid_in = 1'b0; is_load = 1'b0;
    tick; tick;
    check("pre_rst_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    stray_done = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (done) stray_done = 1;
    end
    check("mid_rst_no_done", 32'(stray_done), 32'd0);
    prev_exp_rdata = 32'd0;
    exp_r = model(1'b0, 3'b010, 32'h300, 32'h1122_3344, 32'h0, 0);
    run_access(1'b0, 1'b1, 3'b010, 32'h300, 32'h1122_3344, 32'h0, 0, act_r);
    compare_res("after_rst", exp_r, act_r, 1'b0);

    // Randomized accesses against the model.
    for (int i = 0; i < 40; i++) begin
      logic        ld, st;
      logic [2:0]  f3;
      logic [31:0] a, wd, rd;
      int          d;
      ld = 1'($urandom_range(0, 1));
      st = ld ? 1'($urandom_range(0, 1)) : 1'b1;
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
      wd = $urandom; rd = $urandom;
      d  = $urandom_range(0, 20);
      exp_r = model(ld, f3, a, wd, rd, d);
      run_access(ld, st, f3, a, wd, rd, d, act_r);
      compare_res($sformatf("rand%0d", i), exp_r, act_r, ld);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
- Load/store stage directly downstream of the ALU.
- Takes the ALU result as the effective address and rs2 as store data, then issues one word-aligned request on a req/ack data-memory port.
- For loads, aligns and extends the returned data; for stores, replicates the data and generates byte strobes.
- Raises busy to stall the pipeline and reports faults for misalignment, illegal width and memory timeout.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in WAIT without mem_ack before aborting with a timeout fault; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- valid_in  in  1  access request, sampled only in IDLE.
- is_load  in  1  request is a load.
- is_store  in  1  request is a store; is_load has priority if both are set.
- funct3  in  3  width code: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
- addr  in  32  effective address (ALU out).
- wdata_in  in  32  store data (rs2).
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- rdata_out  out  32  formatted load data; valid when done=1, held until the next done.
- err_code  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3; valid with done, held until next done.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  {addr[31:2],2'b00}.
- mem_wdata  out  32  replicated store data.
- mem_wstrb  out  4  byte enables; 0000 for loads.
- mem_ack  in  1  memory completion, one cycle.
- mem_rdata  in  32  read word, valid with mem_ack.

Behaviour:
- Reset: state=IDLE; done=0, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, rdata_out=0, err_code=00, timeout counter=0.
- Reset mid-operation: at the next edge mem_req drops and state goes to IDLE, with no done pulse.
- FSM states: IDLE, WAIT, RESP.
- IDLE, no access: stays in IDLE if valid_in=0 or is_load=is_store=0.
- IDLE, access accepted: latch op, funct3, addr[1:0], wdata.
- Illegal funct3: loads use 011/110/111; stores use anything except 000/001/010. Go to RESP with err=11 and no memory request.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. Go to RESP with err=01 and no memory request.
- Otherwise go to WAIT. mem_req=1 from the first WAIT cycle; mem_addr/we/wdata/wstrb are registered and stable while in WAIT.
- WAIT, mem_ack=1: capture formatted data, go to RESP with err=00, and deassert mem_req at that edge.
- WAIT, timeout: the counter increments each WAIT cycle without ack. When it reaches TIMEOUT_CYCLES, go to RESP with err=10, deassert mem_req, and leave rdata_out=0.
- WAIT, ack on the same edge as timeout: ack wins.
- RESP: done=1 for exactly one cycle, then IDLE.
- busy is combinational from state, so it is low in the cycle after done. A new valid_in may be accepted in that cycle.
- Minimum latency with ack in the first WAIT cycle: accept at edge 0, mem_req in cycle 1, done in cycle 2.
- mem_ack when mem_req=0 is ignored. valid_in while busy is ignored; it is not queued.
- Store formatting:
  - SB: wdata = byte replicated x4, wstrb = 0001<<addr[1:0].
  - SH: wdata = half replicated x2, wstrb = addr[1] ? 1100 : 0011.
  - SW: wstrb = 1111.
  - Store done has rdata_out=0.
- Load formatting: shift mem_rdata right by 8*addr[1:0], then:
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Faulted accesses never assert mem_req.

Test Plan:
- LB, addr=0x1003, mem_rdata=0x80FF_1234, ack in first WAIT cycle -> mem_addr=0x1000, wstrb=0000; done in cycle 2 with rdata_out=0xFFFF_FF80, err=00.
- SH, addr=0x2002, wdata_in=0x1234_ABCD -> mem_we=1, mem_wdata=0xABCD_ABCD, wstrb=1100; done one cycle after ack; rdata_out=0.
- LW, addr=0x3001 -> no mem_req ever; done on the 2nd edge with err=01. Separately, LHU funct3=101 with data 0x0000_8001 at addr=0x0 -> rdata_out=0x0000_8001.
- Load with mem_ack never asserted, TIMEOUT_CYCLES=16 -> mem_req high exactly 16 cycles, then done with err=10; busy low the following cycle.
- SW with funct3=100 -> err=11, no mem_req. Also: valid_in pulsed while busy is ignored; back-to-back access accepted in the cycle after done.
- rst asserted in the 3rd WAIT cycle -> next edge: mem_req=0, busy=0, no done; the next access completes normally.
